// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter between an ALU result port and
// a buffered memory/load result port, with a load-pending scoreboard.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_valid/alu_ready/rd/data: ALU result handshake (wins unless memory starves)
//   mem_valid/mem_ready/rd/data: load result handshake into a FIFO buffer
//   issue_valid/issue_rd       : load issue, marks destination as pending
//   q1_rd/q1_busy, q2_rd/q2_busy: pending-load queries (combinational)
//   WE3/Addr3/WD3              : registered register-file write port
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q1_rd,
  input  logic [4:0]  q2_rd,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic        WE3,
  output logic [4:0]  Addr3,
  output logic [31:0] WD3
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [31:0]      pending_q, pending_d;

  logic      empty_c;
  logic      push_c;
  logic      alu_grant_c;
  logic      buf_grant_c;
  wb_entry_t head_c;

  // Handshake and grant decisions from registered state
  always_comb begin
    empty_c     = (count_q == '0);
    head_c      = fifo_q[rptr_q];
    mem_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    alu_ready   = !((starve_q == STV_W'(STARVE_MAX)) && !empty_c);
    push_c      = mem_valid && mem_ready;
    alu_grant_c = alu_valid && alu_ready;
    buf_grant_c = !alu_grant_c && !empty_c;
  end

  // Next count, starvation counter and scoreboard
  always_comb begin
    count_d   = count_q;
    starve_d  = starve_q;
    pending_d = pending_q;
    if (push_c && !buf_grant_c) count_d = count_q + CNT_W'(1);
    else if (!push_c && buf_grant_c) count_d = count_q - CNT_W'(1);
    if (empty_c || buf_grant_c) starve_d = '0;
    else if (alu_grant_c && (starve_q != STV_W'(STARVE_MAX))) starve_d = starve_q + STV_W'(1);
    // Clear before set so a same-cycle re-issue keeps the register pending
    if (buf_grant_c) pending_d[head_c.rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
  end

  // Queries never report x0 as busy
  always_comb begin
    q1_busy = pending_q[q1_rd] && (q1_rd != 5'd0);
    q2_busy = pending_q[q2_rd] && (q2_rd != 5'd0);
  end

  // Buffer storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wptr_q] <= '{rd: mem_rd, data: mem_data};
  end

  // Control state and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      WE3       <= 1'b0;
      Addr3     <= 5'd0;
      WD3       <= 32'd0;
    end else begin
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      if (push_c) wptr_q <= wptr_q + PTR_W'(1);
      if (buf_grant_c) rptr_q <= rptr_q + PTR_W'(1);
      // Writes to x0 consume the grant but never assert the enable
      if (alu_grant_c) begin
        WE3   <= (alu_rd != 5'd0);
        Addr3 <= alu_rd;
        WD3   <= alu_data;
      end else if (buf_grant_c) begin
        WE3   <= (head_c.rd != 5'd0);
        Addr3 <= head_c.rd;
        WD3   <= head_c.data;
      end else begin
        WE3   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table for wb_arbiter with a write-port scoreboard,
// plus a hand-written asynchronous-reset sequence.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready, q1_busy, q2_busy, WE3;
  logic [4:0]  alu_rd, mem_rd, issue_rd, q1_rd, q2_rd, Addr3;
  logic [31:0] alu_data, mem_data, WD3;

  wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q1_rd(q1_rd), .q2_rd(q2_rd), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .WE3(WE3), .Addr3(Addr3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird; logic [4:0]  q1;
    logic        ear; logic       emr; logic        eb1;
    logic        ewe; logic [4:0] eaddr; logic [31:0] ewd; logic chk_ad;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] addr; logic [31:0] wd; logic chk_ad; int idx;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic iv, input logic [4:0] ird, input logic [4:0] q1,
    input logic ear, input logic emr, input logic eb1,
    input logic ewe, input logic [4:0] eaddr, input logic [31:0] ewd, input logic chk_ad);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.q1 = q1; v.ear = ear; v.emr = emr; v.eb1 = eb1;
    v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd; v.chk_ad = chk_ad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; q1_rd = 5'd0; q2_rd = 5'd0;
  endtask

  // Compare the write captured at the last rising edge against the scoreboard
  task automatic pop_write();
    wr_t w;
    if (sb.size() == 0) return;
    w = sb.pop_front();
    chk($sformatf("v%0d WE3", w.idx), 32'(WE3), 32'(w.we));
    if (w.chk_ad) begin
      chk($sformatf("v%0d Addr3", w.idx), 32'(Addr3), 32'(w.addr));
      chk($sformatf("v%0d WD3", w.idx), WD3, w.wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    wr_t w;
    //            av ard   ad           mv mrd  md       iv ird q1   ar mr b1  we ad  wd           chk
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,       0, 0,  0,   1, 1, 0,  1, 5,  32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  0,   1, 1, 0,  0, 5,  32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       1, 7,  7,   1, 1, 0,  0, 5,  32'hDEADBEEF, 1));
    vecs.push_back(mk(1, 1,  32'h11,       1, 7,  32'h70,  0, 0,  7,   1, 1, 1,  1, 1,  32'h11,       1));
    vecs.push_back(mk(1, 2,  32'h22,       1, 8,  32'h80,  0, 0,  7,   1, 1, 1,  1, 2,  32'h22,       1));
    vecs.push_back(mk(1, 3,  32'h33,       1, 9,  32'h90,  0, 0,  7,   1, 1, 1,  1, 3,  32'h33,       1));
    vecs.push_back(mk(1, 4,  32'h44,       1, 10, 32'hA0,  0, 0,  7,   1, 1, 1,  1, 4,  32'h44,       1));
    vecs.push_back(mk(1, 6,  32'h66,       1, 11, 32'hB0,  0, 0,  7,   0, 0, 1,  1, 7,  32'h70,       1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       1, 9,  7,   1, 1, 0,  1, 8,  32'h80,       1));
    vecs.push_back(mk(1, 0,  32'hFF,       0, 0,  0,       0, 0,  9,   1, 1, 1,  0, 0,  0,            0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       1, 9,  9,   1, 1, 1,  1, 9,  32'h90,       1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  9,   1, 1, 1,  1, 10, 32'hA0,       1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  9,   1, 1, 1,  0, 10, 32'hA0,       1));
    vecs.push_back(mk(0, 0,  0,            1, 0,  32'h55,  1, 0,  0,   1, 1, 0,  0, 10, 32'hA0,       1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  0,   1, 1, 0,  0, 0,  0,            0));
    vecs.push_back(mk(0, 0,  0,            1, 20, 32'h200, 0, 0,  0,   1, 1, 0,  0, 0,  0,            0));
    vecs.push_back(mk(0, 0,  0,            1, 21, 32'h210, 0, 0,  0,   1, 1, 0,  1, 20, 32'h200,      1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  0,   1, 1, 0,  1, 21, 32'h210,      1));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,       0, 0,  0,   1, 1, 0,  0, 21, 32'h210,      1));

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk("rst WE3", 32'(WE3), 32'd0);
    chk("rst Addr3", 32'(Addr3), 32'd0);
    chk("rst WD3", WD3, 32'd0);
    chk("rst alu_ready", 32'(alu_ready), 32'd1);
    chk("rst mem_ready", 32'(mem_ready), 32'd1);
    chk("rst q1_busy", 32'(q1_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive at falling edge, check combinational outputs, queue the write
    foreach (vecs[i]) begin
      @(negedge clk);
      pop_write();
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; q1_rd = vecs[i].q1; q2_rd = 5'd0;
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      chk($sformatf("v%0d q1_busy", i), 32'(q1_busy), 32'(vecs[i].eb1));
      chk($sformatf("v%0d q2_busy", i), 32'(q2_busy), 32'd0);
      w.we = vecs[i].ewe; w.addr = vecs[i].eaddr; w.wd = vecs[i].ewd;
      w.chk_ad = vecs[i].chk_ad; w.idx = i;
      sb.push_back(w);
    end
    @(negedge clk);
    pop_write();
    idle_inputs();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    // Async reset with three queued loads and a live write
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd12;
    @(negedge clk);
    issue_valid = 1'b0; q1_rd = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h1313; mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'h140;
    @(negedge clk);
    alu_rd = 5'd15; alu_data = 32'h1515; mem_rd = 5'd16; mem_data = 32'h160;
    @(negedge clk);
    alu_rd = 5'd17; alu_data = 32'h1717; mem_rd = 5'd18; mem_data = 32'h180;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("pre-rst WE3", 32'(WE3), 32'd1);
    chk("pre-rst Addr3", 32'(Addr3), 32'd17);
    chk("pre-rst q1_busy", 32'(q1_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async WE3", 32'(WE3), 32'd0);
    chk("async Addr3", 32'(Addr3), 32'd0);
    chk("async WD3", WD3, 32'd0);
    chk("async mem_ready", 32'(mem_ready), 32'd1);
    chk("async alu_ready", 32'(alu_ready), 32'd1);
    chk("async q1_busy", 32'(q1_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d WE3", c), 32'(WE3), 32'd0);
      chk($sformatf("post-rst c%0d q1_busy", c), 32'(q1_busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
